watchdog_multi: RTL
===================

Name: watchdog_multi

Overview:
Multi-channel, parametrised watchdog supervising NUM_CH independent heartbeat sources, e.g. per-subsystem liveness in the AM radio FPGA.
Each channel has its own counter, warning, trigger and optional windowed (too-early heartbeat) fault detection. Channels share global timing parameters.
Also provides a selectable per-channel seconds-remaining readout and a saturating aggregate trip counter for host telemetry.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
CLK_FREQ, 125_000_000, clock cycles per second
TIMEOUT_SEC, 5, timeout in seconds; TIMEOUT_CYCLES = CLK_FREQ*TIMEOUT_SEC
WARN_PCT, 80, warning threshold; WARNING_CYCLES = TIMEOUT_CYCLES*WARN_PCT/100 (integer division)
WINDOW_PCT, 0, early-window threshold; WINDOW_CYCLES = TIMEOUT_CYCLES*WINDOW_PCT/100; 0 disables window mode
STICKY, 0, 1: triggered clears only via force_reset/disable; 0: heartbeat also clears it
CNT_W, 32, per-channel counter width; must hold TIMEOUT_CYCLES

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
enable  in  NUM_CH  per-channel enable
heartbeat  in  NUM_CH  per-channel single-cycle heartbeat pulse
force_reset  in  NUM_CH  per-channel software restart
sel  in  $clog2(NUM_CH) (min 1)  channel selected for time_remaining
triggered  out  NUM_CH  per-channel timeout/fault flag (registered)
warning  out  NUM_CH  per-channel warning flag (registered)
early_fault  out  NUM_CH  sticky window-violation flag (registered)
any_triggered  out  1  OR of triggered (combinational)
time_remaining  out  8  whole seconds remaining on channel sel (combinational)
trip_count  out  8  saturating count of trigger rising edges, all channels

Behaviour:
- Async reset (rstn low): every counter, triggered, warning, early_fault = 0; trip_count = 0. Effective immediately, mid-operation included.
- Per channel, per clk edge, priority highest first:
  1. !enable: counter, triggered, warning, early_fault <= 0
  2. force_reset: counter, triggered, warning, early_fault <= 0
  3. heartbeat && WINDOW_PCT!=0 && counter<WINDOW_CYCLES && !triggered: early fault. early_fault<=1, triggered<=1, warning<=1; counter holds.
  4. heartbeat (valid): counter<=0; warning<=0; triggered<=0 unless STICKY=1 and triggered=1. If sticky-held, counter still clears and warning stays 1.
  5. counter>=TIMEOUT_CYCLES: triggered<=1, warning<=1, counter holds (never exceeds TIMEOUT_CYCLES)
  6. else: counter<=counter+1; warning<=(counter>=WARNING_CYCLES)
- Latency: triggered rises 1 cycle after the edge where counter==TIMEOUT_CYCLES is sampled. From the last restart, that is TIMEOUT_CYCLES+1 edges.
- Invariants: triggered implies warning; counter<=TIMEOUT_CYCLES; triggered=0 while counter<TIMEOUT_CYCLES, except early fault or sticky hold.
- early_fault is sticky: cleared only by rstn, !enable or force_reset.
- Channels are fully independent; simultaneous events on different channels do not interact.
- time_remaining:
  - remaining = TIMEOUT_CYCLES-counter[sel], or 0 if counter>=TIMEOUT_CYCLES
  - output = remaining/CLK_FREQ, saturated to 255; forced to 0 when triggered[sel]
  - sel>=NUM_CH reads 0.
- trip_count: each edge, add the number of channels whose triggered goes 0->1 this cycle (popcount, so simultaneous trips all count). Saturate at 255; no wrap. Cleared only by rstn.
- Heartbeat held high for several cycles is treated as repeated heartbeats; no edge detection inside.

Test Plan:
(CLK_FREQ=10, TIMEOUT_SEC=2 [20 cycles], WARN_PCT=80 [16], NUM_CH=4 unless stated)
- All enabled, no heartbeat -> warning[0] high when counter reaches 17; triggered[0] high at counter 20 plus 1 edge; trip_count=4; time_remaining=0 for every sel.
- ch1 heartbeat at counter 19 -> counter 0, triggered[1] never asserts; time_remaining(sel=1)=2 next cycle; other channels unaffected.
- WINDOW_PCT=25 (5): ch2 heartbeat at counter 3 -> early_fault[2]=1, triggered[2]=1 next cycle; heartbeat at counter 8 on ch3 -> normal restart.
- STICKY=1: trigger ch0, then heartbeat -> triggered[0] stays 1 and counter 0; force_reset[0] -> all ch0 flags 0 next cycle.
- Drive 300 trips via enable toggling -> trip_count saturates at 255; rstn pulse mid-count -> all outputs 0 asynchronously, before the next clk edge.
- enable[3] low while triggered -> ch3 counter/flags 0 next edge; re-enable -> counts from 0, time_remaining(sel=3)=2.

Source files
------------

// File: rtl/watchdog_multi.sv
// Multi-channel heartbeat watchdog. Each channel counts clock cycles since its
// last restart and raises warning/triggered flags as the count approaches and
// reaches the timeout. An optional early window flags heartbeats that arrive
// too soon. A seconds-remaining readout for one selected channel and a
// saturating trip counter are provided for telemetry.
module watchdog_multi #(
    parameter int NUM_CH      = 4,
    parameter int CLK_FREQ    = 125_000_000,
    parameter int TIMEOUT_SEC = 5,
    parameter int WARN_PCT    = 80,
    parameter int WINDOW_PCT  = 0,
    parameter int STICKY      = 0,
    parameter int CNT_W       = 32,
    localparam int SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] enable,
    input  logic [NUM_CH-1:0] heartbeat,
    input  logic [NUM_CH-1:0] force_reset,
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] triggered,
    output logic [NUM_CH-1:0] warning,
    output logic [NUM_CH-1:0] early_fault,
    output logic              any_triggered,
    output logic [7:0]        time_remaining,
    output logic [7:0]        trip_count
);

    // Thresholds are computed in 64 bits so large clock rates cannot overflow
    // before the percentage division.
    localparam logic [63:0] TIMEOUT_64 = 64'(CLK_FREQ) * 64'(TIMEOUT_SEC);
    localparam logic [63:0] WARN_64    = TIMEOUT_64 * 64'(WARN_PCT) / 64'd100;
    localparam logic [63:0] WINDOW_64  = TIMEOUT_64 * 64'(WINDOW_PCT) / 64'd100;
    localparam logic [63:0] FREQ_64    = 64'(CLK_FREQ);

    localparam logic [CNT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_64[CNT_W-1:0];
    localparam logic [CNT_W-1:0] WARNING_CYCLES = WARN_64[CNT_W-1:0];
    localparam logic [CNT_W-1:0] WINDOW_CYCLES  = WINDOW_64[CNT_W-1:0];
    localparam logic [CNT_W-1:0] FREQ_C         = FREQ_64[CNT_W-1:0];
    localparam bit               STICKY_EN      = (STICKY != 0);
    localparam int               SEL_N          = 1 << SEL_W;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] trig_q, trig_d;
    logic [NUM_CH-1:0] warn_q, warn_d;
    logic [NUM_CH-1:0] early_q, early_d;
    logic [7:0]        trip_q, trip_d;
    logic [NUM_CH-1:0] too_early;
    logic [4:0]        rise_cnt;
    logic [8:0]        trip_sum;

    // Window comparison only exists when window mode is configured, so a
    // disabled window never produces a compare against zero.
    generate
        if (WINDOW_PCT != 0) begin : g_win
            // A heartbeat is premature while the count is below the window.
            always_comb begin
                too_early = '0;
                for (int i = 0; i < NUM_CH; i++) begin
                    too_early[i] = (cnt_q[i] < WINDOW_CYCLES);
                end
            end
        end else begin : g_nowin
            assign too_early = '0;
        end
    endgenerate

    // Per-channel next state, highest priority first: disable, software
    // restart, premature heartbeat, heartbeat, timeout hold, count.
    // Warning is held whenever triggered is set so triggered always implies
    // warning, including after a sticky hold or an early fault.
    always_comb begin
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        warn_d  = warn_q;
        early_d = early_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!enable[i] || force_reset[i]) begin
                cnt_d[i]   = '0;
                trig_d[i]  = 1'b0;
                warn_d[i]  = 1'b0;
                early_d[i] = 1'b0;
            end else if (heartbeat[i] && too_early[i] && !trig_q[i]) begin
                early_d[i] = 1'b1;
                trig_d[i]  = 1'b1;
                warn_d[i]  = 1'b1;
            end else if (heartbeat[i]) begin
                cnt_d[i]  = '0;
                trig_d[i] = STICKY_EN && trig_q[i];
                warn_d[i] = STICKY_EN && trig_q[i];
            end else if (cnt_q[i] >= TIMEOUT_CYCLES) begin
                trig_d[i] = 1'b1;
                warn_d[i] = 1'b1;
            end else begin
                cnt_d[i]  = cnt_q[i] + CNT_W'(1);
                warn_d[i] = (cnt_q[i] >= WARNING_CYCLES) || trig_q[i];
            end
        end
    end

    // Count every channel whose triggered flag rises this cycle and add the
    // total to the trip counter, clamping at 255.
    always_comb begin
        rise_cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            rise_cnt = rise_cnt + 5'(trig_d[i] & ~trig_q[i]);
        end
        trip_sum = 9'(trip_q) + 9'(rise_cnt);
        trip_d   = (trip_sum > 9'd255) ? 8'hFF : trip_sum[7:0];
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '{default: '0};
            trig_q  <= '0;
            warn_q  <= '0;
            early_q <= '0;
            trip_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            warn_q  <= warn_d;
            early_q <= early_d;
            trip_q  <= trip_d;
        end
    end

    // Readout tables padded to a power of two; unused select codes are
    // marked invalid so they read as zero.
    logic [CNT_W-1:0] cnt_pad [SEL_N];
    logic [SEL_N-1:0] trig_pad;
    logic [SEL_N-1:0] valid_pad;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W+8:0] secs;

    // Build the padded readout tables.
    always_comb begin
        cnt_pad   = '{default: '0};
        trig_pad  = '0;
        valid_pad = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_pad[i]   = cnt_q[i];
            trig_pad[i]  = trig_q[i];
            valid_pad[i] = 1'b1;
        end
    end

    // Whole seconds left on the selected channel, clamped to 255 and forced
    // to zero once that channel has triggered.
    always_comb begin
        remaining = (cnt_pad[sel] >= TIMEOUT_CYCLES) ? '0 : (TIMEOUT_CYCLES - cnt_pad[sel]);
        secs      = {9'b0, remaining / FREQ_C};
        time_remaining = 8'd0;
        if (valid_pad[sel] && !trig_pad[sel]) begin
            time_remaining = (secs > (CNT_W+9)'(255)) ? 8'hFF : secs[7:0];
        end
    end

    assign triggered     = trig_q;
    assign warning       = warn_q;
    assign early_fault   = early_q;
    assign any_triggered = |trig_q;
    assign trip_count    = trip_q;

endmodule
